// File: rtl/vip_timing_pattern_gen.sv
// Video timing generator with built-in test patterns (bars, gradient, checker, grey).
// Latency: one cycle from counter position to registered sync/href/RGB outputs.
// Backpressure: none; free-running once enabled, frames always complete before stopping.
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   enable                     run request, sampled in IDLE and at the last position of a frame
//   pattern_sel[1:0]           0 bars, 1 gradient, 2 checkerboard, 3 flat grey (latched per frame)
//   per_frame_vsync/hsync/href active-high syncs and data valid
//   per_img_red/green/blue     pixel data, zero outside href
//   frame_done                 one-cycle pulse on the output cycle of the last frame position
//   frame_cnt[15:0]            completed frame count, wraps
// Optional feature: define VTG_HIGHLIGHT_BOX_EN to paint a white box (BOX_X/Y/W/H) over any pattern.
module vip_timing_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BOX_X      = 0,
  parameter int BOX_Y      = 0,
  parameter int BOX_W      = 16,
  parameter int BOX_H      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic                  per_frame_vsync,
  output logic                  per_frame_hsync,
  output logic                  per_frame_href,
  output logic [DATA_WIDTH-1:0] per_img_red,
  output logic [DATA_WIDTH-1:0] per_img_green,
  output logic [DATA_WIDTH-1:0] per_img_blue,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_E = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_E = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_S = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_E = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_S = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_E = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] BAR_W   = 16'(H_ACTIVE / 8);

  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};

  // Elaboration-time parameter sanity checks.
  if ((H_ACTIVE % 8) != 0) begin : g_bad_h_active
    $error("H_ACTIVE must be a multiple of 8");
  end
  if ((BOX_X < 0) || (BOX_Y < 0) || (BOX_W < 0) || (BOX_H < 0)) begin : g_bad_box
    $error("box parameters must be non-negative");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
  logic [1:0]  r_pat, w_pat_nxt;
  logic        w_at_end;

  assign w_at_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    w_pat_nxt   = r_pat;
    case (r_state)
      ST_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_pat_nxt   = pattern_sel;
        end
      end
      ST_RUN: begin
        if (r_h_cnt == H_LAST) begin
          w_h_nxt = '0;
          w_v_nxt = (r_v_cnt == V_LAST) ? 16'd0 : r_v_cnt + 16'd1;
        end else begin
          w_h_nxt = r_h_cnt + 16'd1;
        end
        // enable only matters at the frame boundary, so frames are never cut short.
        if (w_at_end) begin
          w_pat_nxt = pattern_sel;
          if (!enable) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel generation for the current counter position.
  logic [15:0]           w_x, w_y;
  logic [7:0]            w_x8, w_y8;
  logic [2:0]            w_bar;
  logic                  w_href;
  logic [DATA_WIDTH-1:0] w_red, w_green, w_blue;

  assign w_x    = r_h_cnt - H_ACT_S;
  assign w_y    = r_v_cnt - V_ACT_S;
  assign w_x8   = 8'(w_x);
  assign w_y8   = 8'(w_y);
  assign w_bar  = 3'(w_x / BAR_W);
  assign w_href = (r_state == ST_RUN) &&
                  (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E) &&
                  (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);

`ifdef VTG_HIGHLIGHT_BOX_EN
  localparam logic [15:0] BOX_XS = 16'(BOX_X);
  localparam logic [15:0] BOX_XE = 16'(BOX_X + BOX_W);
  localparam logic [15:0] BOX_YS = 16'(BOX_Y);
  localparam logic [15:0] BOX_YE = 16'(BOX_Y + BOX_H);
  logic w_in_box;
  assign w_in_box = (w_x >= BOX_XS) && (w_x < BOX_XE) && (w_y >= BOX_YS) && (w_y < BOX_YE);
`endif

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (w_href) begin
      case (r_pat)
        2'd0: begin
          // Bar order white..black maps onto inverted bar-index bits.
          w_red   = w_bar[1] ? '0 : ONES;
          w_green = w_bar[2] ? '0 : ONES;
          w_blue  = w_bar[0] ? '0 : ONES;
        end
        2'd1: begin
          w_red   = DATA_WIDTH'(w_x8);
          w_green = DATA_WIDTH'(w_y8);
          w_blue  = DATA_WIDTH'(8'(w_x8 + w_y8));
        end
        2'd2: begin
          if (w_x8[3] ^ w_y8[3]) begin
            w_red   = ONES;
            w_green = ONES;
            w_blue  = ONES;
          end
        end
        default: begin
          w_red   = DATA_WIDTH'(frame_cnt[7:0]);
          w_green = DATA_WIDTH'(frame_cnt[7:0]);
          w_blue  = DATA_WIDTH'(frame_cnt[7:0]);
        end
      endcase
`ifdef VTG_HIGHLIGHT_BOX_EN
      if (w_in_box) begin
        w_red   = ONES;
        w_green = ONES;
        w_blue  = ONES;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_frame_vsync <= 1'b0;
      per_frame_hsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_img_red     <= '0;
      per_img_green   <= '0;
      per_img_blue    <= '0;
      frame_done      <= 1'b0;
      frame_cnt       <= '0;
    end else if (r_state == ST_RUN) begin
      per_frame_hsync <= (r_h_cnt < H_SYNC_E);
      per_frame_vsync <= (r_v_cnt < V_SYNC_E);
      per_frame_href  <= w_href;
      per_img_red     <= w_red;
      per_img_green   <= w_green;
      per_img_blue    <= w_blue;
      frame_done      <= w_at_end;
      if (w_at_end) frame_cnt <= frame_cnt + 16'd1;
    end else begin
      per_frame_vsync <= 1'b0;
      per_frame_hsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_img_red     <= '0;
      per_img_green   <= '0;
      per_img_blue    <= '0;
      frame_done      <= 1'b0;
    end
  end

endmodule

// File: doc/vip_timing_pattern_gen.md
VIP_TIMING_PATTERN_GEN -- requirements
Module: vip_timing_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning per-channel pixel width.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal active, front porch, sync and back porch in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical active, front porch, sync and back porch in lines.
REQ-004 SHALL have parameters BOX_X 0, BOX_Y 0, BOX_W 16, BOX_H 16, meaning highlight box origin and size in active pixels.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: run request.
REQ-008 SHALL have port pattern_sel, input, 2 bits: 0 colour bars, 1 gradient, 2 checkerboard, 3 flat grey.
REQ-009 SHALL have ports per_frame_vsync, per_frame_hsync and per_frame_href, each an output, 1 bit: active-high sync and data-valid signals.
REQ-010 SHALL have ports per_img_red, per_img_green and per_img_blue, each an output, DATA_WIDTH bits: pixel data.
REQ-011 SHALL have port frame_done, output, 1 bit: single-cycle end-of-frame pulse.
REQ-012 SHALL have port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-013 SHALL define H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise; h_cnt runs 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1.
REQ-014 SHALL implement states IDLE and RUN; in IDLE, counters are held at 0.
REQ-015 SHALL transition IDLE->RUN when enable=1 is sampled in IDLE; counting starts on the next cycle from (0,0).
REQ-016 SHALL, in RUN, increment h_cnt every cycle; at H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments; at (H_TOTAL-1, V_TOTAL-1), both counters wrap.
REQ-017 SHALL sample enable only at (H_TOTAL-1, V_TOTAL-1): if enable=0, go to IDLE; otherwise stay in RUN. Mid-frame deassertion never truncates a frame.
REQ-018 SHALL assert hsync for h_cnt<H_SYNC and vsync for v_cnt<V_SYNC.
REQ-019 SHALL assert href only when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-020 SHALL define x and y as active-region pixel and line indices, each 0-based.
REQ-021 SHALL register all outputs; outputs at cycle k+1 reflect the counter position at cycle k (latency 1).
REQ-022 SHALL hold sync outputs at 0 in IDLE.
REQ-023 SHALL drive RGB to 0 whenever href=0.
REQ-024 SHALL produce colour bars as 8 equal-width bars, bar=x/(H_ACTIVE/8), in the order white, yellow, cyan, green, magenta, red, blue, black, with each channel at 0 or all-ones; H_ACTIVE SHALL be a multiple of 8.
REQ-025 SHALL produce the gradient as R=x[7:0], G=y[7:0], B=(x+y)[7:0].
REQ-026 SHALL produce the checkerboard as all channels all-ones when x[3]^y[3]=1, else 0.
REQ-027 SHALL produce flat grey as all channels equal to frame_cnt[7:0].
REQ-028 SHALL latch pattern_sel on the IDLE->RUN transition and at each frame wrap; changes to pattern_sel mid-frame SHALL be ignored.
REQ-029 SHALL pulse frame_done for exactly one cycle, aligned with the output cycle of position (H_TOTAL-1, V_TOTAL-1).
REQ-030 SHALL increment frame_cnt on each frame_done pulse, wrapping from 0xFFFF to 0.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state IDLE, counters to 0, and all outputs to 0, including frame_cnt and latched pattern_sel=0.
REQ-032 SHALL abandon any partial frame on reset mid-frame; after release, no output SHALL toggle until enable=1 is sampled.

Configuration
REQ-033 SHALL, with `VTG_HIGHLIGHT_BOX_EN defined, force RGB to all-ones where href=1, x in [BOX_X, BOX_X+BOX_W) and y in [BOX_Y, BOX_Y+BOX_H), overriding every pattern.
REQ-034 SHALL, without `VTG_HIGHLIGHT_BOX_EN, contain no box logic; box parameters are then unused.

Verification (H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 -> H_TOTAL=22; V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> V_TOTAL=7)
REQ-035 SHALL verify: enable=1 continuously, pattern 0 -> per frame 154 cycles, 4 href lines of 16 cycles each, hsync high for 2 cycles/line, vsync high for 22 cycles, first href pixel RGB=FF/FF/FF, pixels x=14..15 = 00/00/00.
REQ-036 SHALL verify: pattern 1 -> pixel x=5, y=2 gives RGB=05/02/07.
REQ-037 SHALL verify: enable dropped at cycle 40 of a frame -> frame completes all 154 cycles, frame_done pulses once, frame_cnt=1, then all outputs 0 in IDLE.
REQ-038 SHALL verify: rst_n low at cycle 60 -> all outputs 0 within the same cycle, frame_cnt=0, and no href after release until enable is seen.
REQ-039 SHALL verify: pattern_sel changed 0->2 mid-frame -> current frame stays bars; next frame is checkerboard with x=8, y=0 -> FF/FF/FF.
REQ-040 SHALL verify: with `VTG_HIGHLIGHT_BOX_EN defined, BOX_X=2, BOX_Y=1, BOX_W=2, BOX_H=1 and pattern 1 -> pixels (2,1) and (3,1) = FF/FF/FF, pixel (4,1) = 04/01/05.
